spu_divider_pipe: RTL and testbench
===================================

# spu_divider_pipe

Pipelined restoring divider for the SPU datapath. It is the parametrised successor of the single-mode unsigned divider and adds the following:
- per-transaction signed/unsigned mode
- a true remainder output
- divide-by-zero detection
- a sideband tag
- a full valid/ready handshake with backpressure

It sits between the SPU operand fetch and the writeback path, and accepts one division per cycle when not stalled.

## Interface
- DIVIDEND_DW, default 8: dividend width.
- DIVISOR_DW, default 8: divisor width.
- FRAC_DW, default 4: extra fractional quotient bits. The dividend is scaled by 2^FRAC_DW.
- QW (derived localparam): DIVIDEND_DW + FRAC_DW, the number of quotient magnitude bits and restoring steps.
- STAGE_MASK, default all ones, width QW: bit QW-1-i set means step i ends in a register; bit clear means step i is combinational.
- TAG_DW, default 4: sideband tag width.

Ports:
- core_clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_vld, input, 1: operand valid.
- in_rdy, output, 1: operand accepted when in_vld & in_rdy.
- in_signed, input, 1: 1 means treat data0 and data1 as two's complement; 0 means unsigned.
- data0, input, DIVIDEND_DW: dividend.
- data1, input, DIVISOR_DW: divisor.
- in_tag, input, TAG_DW: sideband tag, returned unchanged.
- out_vld, output, 1: result valid.
- out_rdy, input, 1: result consumed when out_vld & out_rdy.
- quot, output, QW+1: quotient, two's complement. Zero-extended in unsigned mode.
- rem, output, DIVISOR_DW: remainder.
- dz, output, 1: divide-by-zero flag.
- out_tag, output, TAG_DW: tag of the result.
- busy, output, 1: at least one transaction is in flight or held at the output.

## Operation
**Input conversion**
- Magnitudes |a| (DIVIDEND_DW bits unsigned) and |b| (DIVISOR_DW bits unsigned) are taken in the accept cycle.
- In signed mode the most negative value maps to 2^(DW-1), which is exact and has no overflow.

**Quotient and remainder**
- Q = floor(|a|·2^FRAC_DW / |b|), QW bits. R = |a|·2^FRAC_DW − Q·|b|.
- Step i (i = 0..QW-1) produces quotient bit QW-1-i by restoring compare and subtract against the partial remainder. The partial remainder is DIVISOR_DW+1 bits wide.
- Early-out: if the divisor has a set bit above the current partial-remainder width, the step's quotient bit is 0.

**Sign rules (signed mode only)**
- quot = −Q if sign(a) ≠ sign(b), otherwise Q.
- rem takes the sign of the dividend (truncation toward zero). A zero remainder is always +0.

**Divide by zero (data1 == 0)**
- dz = 1, rem = 0.
- Magnitude is all ones. quot = {1'b0, {QW{1'b1}}}, negated when signed mode and data0 is negative.

**Sideband and ordering**
- in_signed, the dividend sign, the divisor sign, the zero-divisor flag and the tag travel alongside each stage's valid bit.
- Results are strictly in order.

## Timing
**Latency**
- L = popcount(STAGE_MASK) + 1 cycles from the accept edge to out_vld. The +1 is the output register.
- With the default parameters, L = 13.

**Handshake and stall**
- Global stall: adv = ~out_vld | out_rdy.
- in_rdy = adv. This is a combinational path from out_rdy, which is allowed.
- When adv = 0, every stage register and the output register hold.
- The output holds stable while out_vld & ~out_rdy.
- Throughput is 1 per cycle when out_rdy is held high.

**Bubbles**
- in_vld = 0 at an advancing edge inserts a bubble.
- Stage data registers load only when their incoming valid is 1; the valid bits always load on adv.

**Reset**
- Reset values: out_vld = 0, quot = 0, rem = 0, dz = 0, out_tag = 0, busy = 0, and all stage valids = 0. in_rdy = 1 after reset.
- Reset asserted mid-operation discards all in-flight transactions. No partial result is emitted after release.
- Accept and output handshakes in the same cycle are legal: the pipeline advances and the new operand enters.

## Structure
**Package spu_div_pkg**
- Function for the latency (popcount of the mask).
- Struct for the per-stage sideband: sign flags, dz, tag, valid.

**Sub-module spu_div_step**
- One restoring step.
- Parameters: step index, widths, and REG (from the STAGE_MASK bit).
- Registered or combinational according to REG, with the adv enable.
- The top-level module instantiates QW steps in a generate loop and adds the input conversion and the output sign/dz fixup register.

## Test plan
All scenarios use default parameters with out_rdy = 1 unless stated.

- Unsigned 100/7: quot = 0x00E4 (228), rem = 4, dz = 0, out_vld exactly 13 cycles after accept, tag returned.
- Signed −100/7: quot = −228 (0x1F1C), rem = −4 (0xFC). Signed 100/−7: quot = −228, rem = +4.
- Signed −128/−1: quot = 0x0800 (2048), rem = 0, no overflow.
- 5/0 unsigned: dz = 1, quot = 0x0FFF, rem = 0. Signed −5/0: dz = 1, quot = −4095.
- Backpressure: issue 4 back-to-back with tags 1..4, then hold out_rdy low for 6 cycles once the first result appears.
  - Expected: in_rdy low during the hold and results stable during the hold.
  - All 4 results are correct, in tag order, with no drop or duplicate.
- Reset mid-flight: pulse rst_n after 3 accepts. Expected: outputs at reset values, no out_vld afterwards. Rerun with STAGE_MASK = alternating bits and check L = 7.

Source files
------------

// File: rtl/spu_div_pkg.sv
// Shared types and helpers for the SPU pipelined divider.
package spu_div_pkg;

    // Per-stage sideband travelling alongside the datapath of each step.
    // The tag is carried next to it because its width is set per instance.
    typedef struct packed {
        logic vld;    // stage holds a live transaction
        logic sgn;    // transaction uses two's complement operands
        logic a_neg;  // raw sign bit of the dividend
        logic b_neg;  // raw sign bit of the divisor
        logic dz;     // divisor was zero
    } div_sb_t;

    // Accept-to-result latency: one cycle per registered step plus the output register.
    function automatic int unsigned div_latency(input logic [63:0] mask, input int unsigned qw);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < qw; i++) begin
            if (mask[i[5:0]]) begin
                cnt = cnt + 1;
            end
        end
        return cnt + 1;
    endfunction

endpackage

// File: rtl/spu_divider_pipe_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor and shift the resulting quotient bit into the work register.
module spu_div_step
    import spu_div_pkg::*;
#(
    parameter int unsigned STEP       = 0,
    parameter int unsigned QW         = 12,
    parameter int unsigned DIVISOR_DW = 8,
    parameter int unsigned TAG_DW     = 4,
    parameter bit          REG        = 1'b1
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  div_sb_t               sb_i,
    input  logic [TAG_DW-1:0]     tag_i,
    input  logic [DIVISOR_DW:0]   prem_i,
    input  logic [QW-1:0]         work_i,
    input  logic [DIVISOR_DW-1:0] dvs_i,
    output div_sb_t               sb_o,
    output logic [TAG_DW-1:0]     tag_o,
    output logic [DIVISOR_DW:0]   prem_o,
    output logic [QW-1:0]         work_o,
    output logic [DIVISOR_DW-1:0] dvs_o
);

    logic [DIVISOR_DW:0] trial;
    logic [DIVISOR_DW:0] prem_n;
    logic [QW-1:0]       work_n;
    logic                early;
    logic                take;

    // Restoring compare/subtract. The work register holds the unconsumed dividend
    // bits at the top and the quotient bits produced so far at the bottom.
    always_comb begin
        trial = {prem_i[DIVISOR_DW-1:0], work_i[QW-1]};
        // Before this step only STEP+1 dividend bits have entered the remainder,
        // so any divisor bit at or above that position forces a zero quotient bit.
        early = 1'b0;
        for (int unsigned k = STEP + 1; k < DIVISOR_DW; k++) begin
            early = early | dvs_i[k];
        end
        take   = ~early & (prem_i[DIVISOR_DW] | (trial >= {1'b0, dvs_i}));
        prem_n = take ? (trial - {1'b0, dvs_i}) : trial;
        work_n = {work_i[QW-2:0], take};
    end

    if (REG) begin : g_reg
        // Stage register: valid always follows on advance, payload only for live data.
        always_ff @(posedge core_clk or negedge rst_n) begin
            if (!rst_n) begin
                sb_o   <= '0;
                tag_o  <= '0;
                prem_o <= '0;
                work_o <= '0;
                dvs_o  <= '0;
            end else if (adv) begin
                sb_o.vld <= sb_i.vld;
                if (sb_i.vld) begin
                    sb_o   <= sb_i;
                    tag_o  <= tag_i;
                    prem_o <= prem_n;
                    work_o <= work_n;
                    dvs_o  <= dvs_i;
                end
            end
        end
    end else begin : g_comb
        assign sb_o   = sb_i;
        assign tag_o  = tag_i;
        assign prem_o = prem_n;
        assign work_o = work_n;
        assign dvs_o  = dvs_i;
    end

endmodule

// File: rtl/spu_divider_pipe.sv
// Pipelined signed/unsigned restoring divider with fractional quotient bits,
// remainder, divide-by-zero flag, sideband tag and valid/ready backpressure.
module spu_divider_pipe
    import spu_div_pkg::*;
#(
    parameter int unsigned                         DIVIDEND_DW = 8,
    parameter int unsigned                         DIVISOR_DW  = 8,
    parameter int unsigned                         FRAC_DW     = 4,
    parameter logic [DIVIDEND_DW+FRAC_DW-1:0]      STAGE_MASK  = '1,
    parameter int unsigned                         TAG_DW      = 4
) (
    input  logic                           core_clk,
    input  logic                           rst_n,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic                           in_signed,
    input  logic [DIVIDEND_DW-1:0]         data0,
    input  logic [DIVISOR_DW-1:0]          data1,
    input  logic [TAG_DW-1:0]              in_tag,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [DIVIDEND_DW+FRAC_DW:0]   quot,
    output logic [DIVISOR_DW-1:0]          rem,
    output logic                           dz,
    output logic [TAG_DW-1:0]              out_tag,
    output logic                           busy
);

    localparam int unsigned QW = DIVIDEND_DW + FRAC_DW;

    logic adv;

    // Stage-0 operands after input conversion.
    div_sb_t                 sb0;
    logic [TAG_DW-1:0]       tag0;
    logic [DIVISOR_DW:0]     prem0;
    logic [QW-1:0]           work0;
    logic [DIVISOR_DW-1:0]   dvs0;
    logic [DIVIDEND_DW-1:0]  a_mag;
    logic [DIVISOR_DW-1:0]   b_mag;

    // Outputs of step i.
    div_sb_t                 sb_s   [QW];
    logic [TAG_DW-1:0]       tag_s  [QW];
    logic [DIVISOR_DW:0]     prem_s [QW];
    logic [QW-1:0]           work_s [QW];
    logic [DIVISOR_DW-1:0]   dvs_s  [QW];
    logic [QW-1:0]           vld_reg;

    // Output fixup.
    div_sb_t                 sb_l;
    logic [QW-1:0]           q_mag;
    logic                    q_neg;
    logic [QW:0]             quot_n;
    logic [DIVISOR_DW-1:0]   r_mag;
    logic                    r_neg;
    logic [DIVISOR_DW-1:0]   rem_n;
    logic                    unused_dvs;

    assign adv    = ~out_vld | out_rdy;
    assign in_rdy = adv;
    // Combinational steps only mirror upstream valids, so only registered ones count.
    assign busy   = out_vld | (|vld_reg);

    // Input conversion: magnitudes and sign sideband for the accepted operands.
    always_comb begin
        a_mag = (in_signed & data0[DIVIDEND_DW-1]) ? -data0 : data0;
        b_mag = (in_signed & data1[DIVISOR_DW-1])  ? -data1 : data1;
        sb0   = '{vld:   in_vld,
                  sgn:   in_signed,
                  a_neg: data0[DIVIDEND_DW-1],
                  b_neg: data1[DIVISOR_DW-1],
                  dz:    (data1 == '0)};
        tag0  = in_tag;
        prem0 = '0;
        work0 = QW'(a_mag) << FRAC_DW;
        dvs0  = b_mag;
    end

    for (genvar i = 0; i < QW; i++) begin : g_step
        div_sb_t               sb_in;
        logic [TAG_DW-1:0]     tag_in;
        logic [DIVISOR_DW:0]   prem_in;
        logic [QW-1:0]         work_in;
        logic [DIVISOR_DW-1:0] dvs_in;

        if (i == 0) begin : g_first
            assign sb_in   = sb0;
            assign tag_in  = tag0;
            assign prem_in = prem0;
            assign work_in = work0;
            assign dvs_in  = dvs0;
        end else begin : g_next
            assign sb_in   = sb_s[i-1];
            assign tag_in  = tag_s[i-1];
            assign prem_in = prem_s[i-1];
            assign work_in = work_s[i-1];
            assign dvs_in  = dvs_s[i-1];
        end

        spu_div_step #(
            .STEP       (i),
            .QW         (QW),
            .DIVISOR_DW (DIVISOR_DW),
            .TAG_DW     (TAG_DW),
            .REG        (STAGE_MASK[QW-1-i])
        ) u_step (
            .core_clk (core_clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .sb_i     (sb_in),
            .tag_i    (tag_in),
            .prem_i   (prem_in),
            .work_i   (work_in),
            .dvs_i    (dvs_in),
            .sb_o     (sb_s[i]),
            .tag_o    (tag_s[i]),
            .prem_o   (prem_s[i]),
            .work_o   (work_s[i]),
            .dvs_o    (dvs_s[i])
        );

        assign vld_reg[i] = STAGE_MASK[QW-1-i] ? sb_s[i].vld : 1'b0;
    end

    // The last step's divisor copy has no consumer.
    assign unused_dvs = ^dvs_s[QW-1];

    // Sign and divide-by-zero fixup of the final quotient and remainder.
    always_comb begin
        sb_l   = sb_s[QW-1];
        q_mag  = sb_l.dz ? '1 : work_s[QW-1];
        q_neg  = sb_l.sgn & (sb_l.dz ? sb_l.a_neg : (sb_l.a_neg ^ sb_l.b_neg));
        quot_n = q_neg ? -{1'b0, q_mag} : {1'b0, q_mag};
        r_mag  = prem_s[QW-1][DIVISOR_DW-1:0];
        r_neg  = sb_l.sgn & sb_l.a_neg & (prem_s[QW-1] != '0);
        rem_n  = sb_l.dz ? '0 : (r_neg ? -r_mag : r_mag);
    end

    // Output register: holds while the consumer stalls.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            dz      <= 1'b0;
            out_tag <= '0;
        end else if (adv) begin
            out_vld <= sb_l.vld;
            if (sb_l.vld) begin
                quot    <= quot_n;
                rem     <= rem_n;
                dz      <= sb_l.dz;
                out_tag <= tag_s[QW-1];
            end
        end
    end

endmodule

// File: tb/tb_spu_divider_pipe.sv
// Scoreboard bench for spu_divider_pipe: default fully-registered instance and an
// alternating-mask instance, each with its own expectation queue and monitor.
module tb_spu_divider_pipe;

    typedef struct {
        logic [12:0] quot;
        logic [7:0]  rem;
        logic        dz;
        logic [3:0]  tag;
        int          acc;
        logic        chk_lat;
    } exp_t;

    logic        core_clk = 1'b0;
    logic        rst_n    = 1'b1;
    int          cyc      = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    logic        lat_chk  = 1'b0;
    int          pending [2];

    logic        in_vld_a    [2];
    logic        in_rdy_a    [2];
    logic        in_signed_a [2];
    logic [7:0]  data0_a     [2];
    logic [7:0]  data1_a     [2];
    logic [3:0]  in_tag_a    [2];
    logic        out_vld_a   [2];
    logic        out_rdy_a   [2];
    logic [12:0] quot_a      [2];
    logic [7:0]  rem_a       [2];
    logic        dz_a        [2];
    logic [3:0]  out_tag_a   [2];
    logic        busy_a      [2];

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the specified rules.
    function automatic exp_t ref_div(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] tag);
        exp_t   e;
        longint av, bv, am, bm, qm, rm, q, r;
        av = sgn ? longint'($signed(a)) : longint'(a);
        bv = sgn ? longint'($signed(b)) : longint'(b);
        am = (av < 0) ? -av : av;
        bm = (bv < 0) ? -bv : bv;
        if (bm == 0) begin
            qm   = 4095;
            q    = (av < 0) ? -qm : qm;
            r    = 0;
            e.dz = 1'b1;
        end else begin
            qm   = (am * 16) / bm;
            rm   = (am * 16) % bm;
            q    = ((av < 0) != (bv < 0)) ? -qm : qm;
            r    = (av < 0) ? -rm : rm;
            e.dz = 1'b0;
        end
        e.quot    = q[12:0];
        e.rem     = r[7:0];
        e.tag     = tag;
        e.acc     = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam logic [11:0] MASK    = (g == 0) ? 12'hFFF : 12'hAAA;
        localparam int          EXP_LAT = (g == 0) ? 13 : 7;

        spu_divider_pipe #(
            .DIVIDEND_DW (8),
            .DIVISOR_DW  (8),
            .FRAC_DW     (4),
            .STAGE_MASK  (MASK),
            .TAG_DW      (4)
        ) u_dut (
            .core_clk  (core_clk),
            .rst_n     (rst_n),
            .in_vld    (in_vld_a[g]),
            .in_rdy    (in_rdy_a[g]),
            .in_signed (in_signed_a[g]),
            .data0     (data0_a[g]),
            .data1     (data1_a[g]),
            .in_tag    (in_tag_a[g]),
            .out_vld   (out_vld_a[g]),
            .out_rdy   (out_rdy_a[g]),
            .quot      (quot_a[g]),
            .rem       (rem_a[g]),
            .dz        (dz_a[g]),
            .out_tag   (out_tag_a[g]),
            .busy      (busy_a[g])
        );

        exp_t        exp_q [$];
        exp_t        e;
        logic        hold_prev = 1'b0;
        logic        seen      = 1'b0;
        int          seen_cyc  = 0;
        logic [12:0] h_quot;
        logic [7:0]  h_rem;
        logic        h_dz;
        logic [3:0]  h_tag;

        // Monitor and accept tracker, sampled on the falling edge.
        always @(negedge core_clk) begin
            if (!rst_n) begin
                exp_q.delete();
                pending[g] = 0;
                hold_prev  = 1'b0;
                seen       = 1'b0;
            end else begin
                if (hold_prev) begin
                    check($sformatf("dut%0d hold out_vld", g), out_vld_a[g], 1);
                    check($sformatf("dut%0d hold quot", g), quot_a[g], h_quot);
                    check($sformatf("dut%0d hold rem", g), rem_a[g], h_rem);
                    check($sformatf("dut%0d hold dz", g), dz_a[g], h_dz);
                    check($sformatf("dut%0d hold tag", g), out_tag_a[g], h_tag);
                end
                if (out_vld_a[g] && !out_rdy_a[g]) begin
                    check($sformatf("dut%0d in_rdy during stall", g), in_rdy_a[g], 0);
                    h_quot    = quot_a[g];
                    h_rem     = rem_a[g];
                    h_dz      = dz_a[g];
                    h_tag     = out_tag_a[g];
                    hold_prev = 1'b1;
                end else begin
                    hold_prev = 1'b0;
                end
                if (out_vld_a[g] && !seen) begin
                    seen     = 1'b1;
                    seen_cyc = cyc;
                end
                if (out_vld_a[g] && out_rdy_a[g]) begin
                    seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        check($sformatf("dut%0d unexpected out_vld", g), out_vld_a[g], 0);
                    end else begin
                        e = exp_q.pop_front();
                        pending[g] = pending[g] - 1;
                        check($sformatf("dut%0d quot", g), quot_a[g], e.quot);
                        check($sformatf("dut%0d rem", g), rem_a[g], e.rem);
                        check($sformatf("dut%0d dz", g), dz_a[g], e.dz);
                        check($sformatf("dut%0d tag", g), out_tag_a[g], e.tag);
                        if (e.chk_lat) begin
                            check($sformatf("dut%0d latency", g), seen_cyc - e.acc, EXP_LAT);
                        end
                    end
                end
                if (in_vld_a[g] && in_rdy_a[g]) begin
                    e = ref_div(in_signed_a[g], data0_a[g], data1_a[g], in_tag_a[g]);
                    e.acc     = cyc;
                    e.chk_lat = lat_chk;
                    exp_q.push_back(e);
                    pending[g] = pending[g] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk_reset();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("dut%0d reset out_vld", g), out_vld_a[g], 0);
            check($sformatf("dut%0d reset quot", g), quot_a[g], 0);
            check($sformatf("dut%0d reset rem", g), rem_a[g], 0);
            check($sformatf("dut%0d reset dz", g), dz_a[g], 0);
            check($sformatf("dut%0d reset tag", g), out_tag_a[g], 0);
            check($sformatf("dut%0d reset busy", g), busy_a[g], 0);
            check($sformatf("dut%0d reset in_rdy", g), in_rdy_a[g], 1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((pending[0] != 0 || pending[1] != 0) && n < 300) begin
            tick();
            n++;
        end
        tick();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("dut%0d drained", g), pending[g], 0);
            check($sformatf("dut%0d idle busy", g), busy_a[g], 0);
        end
    endtask

    task automatic directed(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        for (int g = 0; g < 2; g++) begin
            in_vld_a[g]    = 1'b1;
            in_signed_a[g] = sgn;
            data0_a[g]     = a;
            data1_a[g]     = b;
            in_tag_a[g]    = 4'($urandom);
        end
        tick();
        for (int g = 0; g < 2; g++) in_vld_a[g] = 1'b0;
        tick();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("dut%0d busy in flight", g), busy_a[g], 1);
        end
        wait_drain();
    endtask

    task automatic rand_op(input int g);
        in_signed_a[g] = 1'($urandom);
        data0_a[g]     = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        data1_a[g]     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        in_tag_a[g]    = 4'($urandom);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            in_vld_a[g]    = 1'b0;
            in_signed_a[g] = 1'b0;
            data0_a[g]     = '0;
            data1_a[g]     = '0;
            in_tag_a[g]    = '0;
            out_rdy_a[g]   = 1'b1;
            pending[g]     = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk_reset();
        rst_n = 1'b1;
        tick();

        // Directed corner cases with latency checking on an idle pipe.
        lat_chk = 1'b1;
        directed(1'b0, 8'd100, 8'd7);
        directed(1'b1, 8'h9C, 8'd7);
        directed(1'b1, 8'd100, 8'hF9);
        directed(1'b1, 8'h80, 8'hFF);
        directed(1'b0, 8'd5, 8'd0);
        directed(1'b1, 8'hFB, 8'd0);
        directed(1'b0, 8'hFF, 8'd1);
        directed(1'b1, 8'h80, 8'h80);
        for (int k = 0; k < 6; k++) begin
            directed(1'($urandom), 8'($urandom), 8'($urandom));
        end
        lat_chk = 1'b0;

        // Random streaming with random backpressure on both instances.
        for (int k = 0; k < 400; k++) begin
            for (int g = 0; g < 2; g++) begin
                in_vld_a[g]  = ($urandom_range(0, 3) != 0);
                out_rdy_a[g] = ($urandom_range(0, 3) != 0);
                rand_op(g);
            end
            tick();
        end
        for (int g = 0; g < 2; g++) begin
            in_vld_a[g]  = 1'b0;
            out_rdy_a[g] = 1'b1;
        end
        wait_drain();

        // Backpressure: four back-to-back, then a six-cycle stall with a fifth waiting.
        for (int t = 1; t <= 4; t++) begin
            in_vld_a[0] = 1'b1;
            rand_op(0);
            in_tag_a[0] = 4'(t);
            tick();
        end
        in_vld_a[0] = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_vld_a[0] && n < 40) begin
                tick();
                n++;
            end
            check("dut0 first result appears", out_vld_a[0], 1);
        end
        out_rdy_a[0] = 1'b0;
        in_vld_a[0]  = 1'b1;
        rand_op(0);
        in_tag_a[0]  = 4'd5;
        repeat (6) tick();
        out_rdy_a[0] = 1'b1;
        tick();
        in_vld_a[0] = 1'b0;
        wait_drain();

        // Reset mid-flight discards everything in the pipe.
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < 2; g++) begin
                in_vld_a[g] = 1'b1;
                rand_op(g);
            end
            tick();
        end
        for (int g = 0; g < 2; g++) in_vld_a[g] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                check($sformatf("dut%0d no out_vld after reset", g), out_vld_a[g], 0);
            end
        end
        lat_chk = 1'b1;
        directed(1'b0, 8'd100, 8'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
